// File: rtl/vga_vram_arbiter.sv
// Arbitrates one single-port synchronous VRAM between fixed-latency display fetches and
// handshaked CPU reads/writes, with a starvation override that lets a waiting CPU pre-empt the display.
module vga_vram_arbiter #(
   parameter int unsigned AddrWidth   = 12,
   parameter int unsigned DataWidth   = 16,
   parameter int unsigned StarveLimit = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   // display fetch port
   input  logic                 disp_req_i,
   input  logic [AddrWidth-1:0] disp_addr_i,
   output logic [DataWidth-1:0] disp_data_o,
   output logic                 disp_valid_o,
   output logic                 disp_miss_o,
   // CPU bus port
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [AddrWidth-1:0] cpu_addr_i,
   input  logic [DataWidth-1:0] cpu_wdata_i,
   output logic                 cpu_ack_o,
   output logic [DataWidth-1:0] cpu_rdata_o,
   // VRAM port
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic                 mem_we_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {CIdle, CWr, CRd1, CRd2} cpu_st_e;

   cpu_st_e                cpu_st_q;
   logic [7:0]             starve_cnt_q, starve_cnt_d;
   logic [1:0]             disp_tag_q;
   logic [DataWidth-1:0]   disp_data_q;
   logic                   disp_valid_q;
   logic                   disp_miss_q;
   logic                   cpu_ack_q;
   logic [DataWidth-1:0]   cpu_rdata_q;
   logic [AddrWidth-1:0]   mem_addr_q;
   logic                   mem_we_q;
   logic [DataWidth-1:0]   mem_wdata_q;

   logic cpu_elig;
   logic starved;
   logic cpu_grant;
   logic disp_grant;
   logic disp_drop;

   // A request is not re-sampled while its own ack is still visible.
   always_comb begin
      cpu_elig   = cpu_req_i && (cpu_st_q == CIdle) && !cpu_ack_q;
      starved    = (StarveLimit != 0) && (32'(starve_cnt_q) >= StarveLimit);
      cpu_grant  = cpu_elig && (!disp_req_i || starved);
      disp_grant = disp_req_i && !cpu_grant;
      disp_drop  = disp_req_i && cpu_grant;
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!cpu_req_i || cpu_grant) begin
         starve_cnt_d = 8'd0;
      end else if (cpu_elig && (starve_cnt_q != 8'hFF)) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_st_q     <= CIdle;
         starve_cnt_q <= 8'd0;
         disp_tag_q   <= 2'b00;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
         disp_miss_q  <= 1'b0;
         cpu_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         cpu_ack_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         disp_miss_q  <= disp_drop;
         // Stage tags track which RAM read slot belongs to the display.
         disp_tag_q   <= {disp_tag_q[0], disp_grant};
         disp_valid_q <= disp_tag_q[1];
         if (disp_tag_q[1]) begin
            disp_data_q <= mem_rdata_i;
         end

         if (disp_grant) begin
            mem_addr_q <= disp_addr_i;
         end else if (cpu_grant) begin
            mem_addr_q <= cpu_addr_i;
            mem_we_q   <= cpu_we_i;
            if (cpu_we_i) begin
               mem_wdata_q <= cpu_wdata_i;
            end
         end

         case (cpu_st_q)
            CIdle: begin
               if (cpu_grant) begin
                  cpu_st_q <= cpu_we_i ? CWr : CRd1;
               end
            end
            CWr: begin
               cpu_ack_q <= 1'b1;
               cpu_st_q  <= CIdle;
            end
            CRd1: begin
               cpu_st_q <= CRd2;
            end
            CRd2: begin
               cpu_rdata_q <= mem_rdata_i;
               cpu_ack_q   <= 1'b1;
               cpu_st_q    <= CIdle;
            end
            default: begin
               cpu_st_q <= CIdle;
            end
         endcase
      end
   end

   assign disp_data_o  = disp_data_q;
   assign disp_valid_o = disp_valid_q;
   assign disp_miss_o  = disp_miss_q;
   assign cpu_ack_o    = cpu_ack_q;
   assign cpu_rdata_o  = cpu_rdata_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_we_o     = mem_we_q;
   assign mem_wdata_o  = mem_wdata_q;

`ifndef SYNTHESIS
   ack_single_cycle: assert property (@(posedge clk) disable iff (rst) cpu_ack_q |=> !cpu_ack_q);
   we_only_for_cpu_write: assert property (@(posedge clk) disable iff (rst)
      mem_we_q |-> (cpu_st_q == CWr));
   if ((StarveLimit != 0) && (StarveLimit < 255)) begin : g_starve_chk
      starve_bounded: assert property (@(posedge clk) disable iff (rst)
         32'(starve_cnt_q) <= StarveLimit);
   end
`endif

endmodule
